// File: rtl/data_table_ram_arb_pkg.sv
// Shared types for the hash-table data RAM: word layout, pointer width, arbitration modes
// and the arbiter/clear state encoding.
package data_table_ram_arb_pkg;

   localparam int HEAD_PTR_WIDTH = 10;

   typedef struct packed {
      logic                      valid;
      logic [15:0]               key;
      logic [4:0]                value;
      logic [HEAD_PTR_WIDTH-1:0] next_ptr;
   } ram_data_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_e;

endpackage

// File: rtl/data_table_ram_arb_if.sv
// Engine-side request/grant/data bundle for the data RAM arbiter; master = engines,
// slave = arbiter. Channel i occupies slice [i*WIDTH +: WIDTH] of each packed bus.
interface data_table_ram_arb_if #(
   parameter int CH_CNT  = 2,
   parameter int A_WIDTH = 10,
   parameter int D_WIDTH = 32
);
   logic [CH_CNT-1:0]         rd_req;
   logic [CH_CNT*A_WIDTH-1:0] rd_addr;
   logic [CH_CNT-1:0]         rd_gnt;
   logic [D_WIDTH-1:0]        rd_data;
   logic [CH_CNT-1:0]         rd_data_val;
   logic [CH_CNT-1:0]         wr_req;
   logic [CH_CNT*A_WIDTH-1:0] wr_addr;
   logic [CH_CNT*D_WIDTH-1:0] wr_data;
   logic [CH_CNT-1:0]         wr_gnt;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  rd_gnt, rd_data, rd_data_val, wr_gnt
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output rd_gnt, rd_data, rd_data_val, wr_gnt
   );
endinterface

// File: rtl/data_table_ram_arb_rr_arbiter.sv
// N-way one-hot arbiter, combinational grant; fixed (highest index) or round-robin.
// Pointer advances only on a granted cycle; advance_i low forces no grant and holds the pointer.
module rr_arbiter
   import data_table_ram_arb_pkg::*;
#(
   parameter int N    = 2,
   parameter int MODE = ARB_RR
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         advance_i,
   output logic [N-1:0] gnt_o
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      if (advance_i) begin
         if (MODE == ARB_FIXED) begin
            for (int i = 0; i < N; i++) begin
               if (req_i[i]) begin
                  gnt_o    = '0;
                  gnt_o[i] = 1'b1;
               end
            end
         end else begin
            // Walk offsets far-to-near so the nearest requester after the pointer wins.
            for (int off = N - 1; off >= 0; off--) begin
               for (int i = 0; i < N; i++) begin
                  if (((int'(ptr_q) + off) % N == i) && req_i[i]) begin
                     gnt_o    = '0;
                     gnt_o[i] = 1'b1;
                     ptr_d    = PW'((i + 1) % N);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/data_table_ram_arb.sv
// Arbitrates CH_CNT engine read/write channels onto the data RAM ports with zero added latency,
// returns read data tagged after RAM_LATENCY cycles, and runs a lock-out zero-fill clear sweep.
module data_table_ram_arb
   import data_table_ram_arb_pkg::*;
#(
   parameter int CH_CNT      = 2,
   parameter int A_WIDTH     = HEAD_PTR_WIDTH,
   parameter int D_WIDTH     = $bits(ram_data_t),
   parameter int RAM_LATENCY = 2,
   parameter int ARB_MODE    = ARB_RR
) (
   input  logic               clk_i,
   input  logic               rst_i,
   data_table_ram_arb_if.slave eng,
   input  logic               clear_ram_run_i,
   output logic               clear_ram_done_o,
   output logic               busy_o,
   output logic [A_WIDTH-1:0] ram_rd_addr_o,
   output logic               ram_rd_en_o,
   input  logic [D_WIDTH-1:0] ram_rd_data_i,
   output logic [A_WIDTH-1:0] ram_wr_addr_o,
   output logic [D_WIDTH-1:0] ram_wr_data_o,
   output logic               ram_wr_en_o
);
   localparam logic [A_WIDTH-1:0] ADDR_ONE  = A_WIDTH'(1);
   localparam logic [A_WIDTH-1:0] ADDR_LAST = '1;

   arb_state_e         state_q, state_d;
   logic [A_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic [CH_CNT-1:0]  tag_q [RAM_LATENCY];
   logic [CH_CNT-1:0]  rd_gnt, wr_gnt;
   logic               arb_en;

   assign arb_en = (state_q == ST_IDLE);
   assign busy_o = (state_q == ST_CLEAR);

   rr_arbiter #(.N(CH_CNT), .MODE(ARB_MODE)) u_rd_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (eng.rd_req),
      .advance_i (arb_en),
      .gnt_o     (rd_gnt)
   );

   rr_arbiter #(.N(CH_CNT), .MODE(ARB_MODE)) u_wr_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (eng.wr_req),
      .advance_i (arb_en),
      .gnt_o     (wr_gnt)
   );

   assign eng.rd_gnt      = rd_gnt;
   assign eng.wr_gnt      = wr_gnt;
   assign eng.rd_data     = ram_rd_data_i;
   assign eng.rd_data_val = tag_q[RAM_LATENCY-1];

   // A restart request wins over the terminal address, so an aborted sweep never signals done.
   always_comb begin
      state_d          = state_q;
      clr_addr_d       = clr_addr_q;
      clear_ram_done_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_ram_run_i) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            if (clear_ram_run_i) begin
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_ONE;
               if (clr_addr_q == ADDR_LAST) begin
                  state_d          = ST_IDLE;
                  clear_ram_done_o = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ram_rd_en_o   = |rd_gnt;
      ram_rd_addr_o = '0;
      ram_wr_en_o   = 1'b0;
      ram_wr_addr_o = '0;
      ram_wr_data_o = '0;
      for (int i = 0; i < CH_CNT; i++) begin
         if (rd_gnt[i]) ram_rd_addr_o = eng.rd_addr[i*A_WIDTH +: A_WIDTH];
      end
      if (state_q == ST_CLEAR) begin
         ram_wr_en_o   = 1'b1;
         ram_wr_addr_o = clr_addr_q;
      end else begin
         ram_wr_en_o = |wr_gnt;
         for (int i = 0; i < CH_CNT; i++) begin
            if (wr_gnt[i]) begin
               ram_wr_addr_o = eng.wr_addr[i*A_WIDTH +: A_WIDTH];
               ram_wr_data_o = eng.wr_data[i*D_WIDTH +: D_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         clr_addr_q <= '0;
         for (int k = 0; k < RAM_LATENCY; k++) tag_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         tag_q[0]   <= rd_gnt;
         for (int k = 1; k < RAM_LATENCY; k++) tag_q[k] <= tag_q[k-1];
      end
   end

endmodule

// File: tb/tb_data_table_ram_arb.sv
// Directed bench: round-robin DUT with a 2-cycle RAM model, plus a fixed-priority DUT.
module tb_data_table_ram_arb;
   import data_table_ram_arb_pkg::*;

   localparam int CH = 3;
   localparam int AW = 4;
   localparam int DW = 32;

   logic clk, rst;
   int   n_vec = 0;
   int   n_err = 0;

   data_table_ram_arb_if #(.CH_CNT(CH), .A_WIDTH(AW), .D_WIDTH(DW)) eng_a ();
   data_table_ram_arb_if #(.CH_CNT(CH), .A_WIDTH(AW), .D_WIDTH(DW)) eng_b ();

   logic          run_a, done_a, busy_a, rd_en_a, wr_en_a;
   logic [AW-1:0] rd_addr_a, wr_addr_a;
   logic [DW-1:0] rd_data_a, wr_data_a;
   logic          run_b, done_b, busy_b, rd_en_b, wr_en_b;
   logic [AW-1:0] rd_addr_b, wr_addr_b;
   logic [DW-1:0] rd_data_b, wr_data_b;

   data_table_ram_arb #(.CH_CNT(CH), .A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(2), .ARB_MODE(ARB_RR)) dut_a (
      .clk_i(clk), .rst_i(rst), .eng(eng_a),
      .clear_ram_run_i(run_a), .clear_ram_done_o(done_a), .busy_o(busy_a),
      .ram_rd_addr_o(rd_addr_a), .ram_rd_en_o(rd_en_a), .ram_rd_data_i(rd_data_a),
      .ram_wr_addr_o(wr_addr_a), .ram_wr_data_o(wr_data_a), .ram_wr_en_o(wr_en_a)
   );

   data_table_ram_arb #(.CH_CNT(CH), .A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(2), .ARB_MODE(ARB_FIXED)) dut_b (
      .clk_i(clk), .rst_i(rst), .eng(eng_b),
      .clear_ram_run_i(run_b), .clear_ram_done_o(done_b), .busy_o(busy_b),
      .ram_rd_addr_o(rd_addr_b), .ram_rd_en_o(rd_en_b), .ram_rd_data_i(rd_data_b),
      .ram_wr_addr_o(wr_addr_b), .ram_wr_data_o(wr_data_b), .ram_wr_en_o(wr_en_b)
   );

   // RAM model: write at the edge, read data two edges after the enable, old data on collision.
   logic [DW-1:0] mem [16];
   logic [DW-1:0] p1, p2;
   always @(posedge clk) begin
      if (wr_en_a) mem[wr_addr_a] <= wr_data_a;
      if (rd_en_a) p1 <= mem[rd_addr_a];
      p2 <= p1;
   end
   assign rd_data_a = p2;
   assign rd_data_b = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wrd(input int a);
      return 32'hC0DE_0000 + 32'(a);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [2:0] rd_req;
      logic [2:0] wr_req;
      logic [2:0] exp_rd_gnt;
      logic [2:0] exp_wr_gnt;
      logic [2:0] exp_val;
   } vec_t;

   vec_t vt [11];
   int   done_cnt;
   logic bad;

   initial begin
      vt[0]  = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
      vt[1]  = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000};
      vt[2]  = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b000};
      vt[3]  = '{3'b111, 3'b000, 3'b001, 3'b000, 3'b000};
      vt[4]  = '{3'b111, 3'b000, 3'b010, 3'b000, 3'b000};
      vt[5]  = '{3'b111, 3'b000, 3'b100, 3'b000, 3'b001};
      vt[6]  = '{3'b111, 3'b000, 3'b001, 3'b000, 3'b010};
      vt[7]  = '{3'b111, 3'b000, 3'b010, 3'b000, 3'b100};
      vt[8]  = '{3'b111, 3'b000, 3'b100, 3'b000, 3'b001};
      vt[9]  = '{3'b000, 3'b011, 3'b000, 3'b001, 3'b010};
      vt[10] = '{3'b000, 3'b011, 3'b000, 3'b010, 3'b100};

      rst = 1'b1; run_a = 1'b0; run_b = 1'b0;
      eng_a.rd_req = '0; eng_a.wr_req = '0;
      eng_a.rd_addr = {4'd7, 4'd6, 4'd5};
      eng_a.wr_addr = {4'd7, 4'd6, 4'd5};
      eng_a.wr_data = {wrd(7), wrd(6), wrd(5)};
      eng_b.rd_req = '0; eng_b.wr_req = '0;
      eng_b.rd_addr = {4'd7, 4'd6, 4'd5};
      eng_b.wr_addr = {4'd7, 4'd6, 4'd5};
      eng_b.wr_data = {wrd(7), wrd(6), wrd(5)};
      repeat (3) step();
      rst = 1'b0;
      #2;
      chk("rst_rd_gnt", 32'(eng_a.rd_gnt), 0);
      chk("rst_val", 32'(eng_a.rd_data_val), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_ram_en", {30'd0, rd_en_a, wr_en_a}, 0);

      // Table: preload 5/6/7 via writes, round-robin reads, then write contention.
      for (int v = 0; v < 11; v++) begin
         step();
         eng_a.rd_req = vt[v].rd_req;
         eng_a.wr_req = vt[v].wr_req;
         #2;
         chk($sformatf("v%0d_rd_gnt", v), 32'(eng_a.rd_gnt), 32'(vt[v].exp_rd_gnt));
         chk($sformatf("v%0d_wr_gnt", v), 32'(eng_a.wr_gnt), 32'(vt[v].exp_wr_gnt));
         chk($sformatf("v%0d_val", v), 32'(eng_a.rd_data_val), 32'(vt[v].exp_val));
         chk($sformatf("v%0d_ram_en", v), {30'd0, rd_en_a, wr_en_a},
             {30'd0, |vt[v].exp_rd_gnt, |vt[v].exp_wr_gnt});
         for (int c = 0; c < CH; c++) begin
            if (vt[v].exp_rd_gnt[c]) chk($sformatf("v%0d_rd_addr", v), 32'(rd_addr_a), 32'(5 + c));
            if (vt[v].exp_val[c]) chk($sformatf("v%0d_rd_data", v), eng_a.rd_data, wrd(5 + c));
         end
      end
      step();
      eng_a.rd_req = '0; eng_a.wr_req = '0;

      // Fixed priority: channel 1 always beats channel 0.
      eng_b.rd_req = 3'b011;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("fixed_rd_gnt", 32'(eng_b.rd_gnt), 32'b010);
         chk("fixed_rd_addr", 32'(rd_addr_b), 6);
         step();
      end
      eng_b.rd_req = '0;
      eng_b.wr_req = 3'b111;
      #2;
      chk("fixed_wr_gnt", 32'(eng_b.wr_gnt), 32'b100);
      step();
      eng_b.wr_req = '0;

      // Clear sweep with a write held off for the whole sweep.
      run_a = 1'b1;
      #2;
      chk("clr_start_busy", 32'(busy_a), 0);
      step();
      run_a = 1'b0;
      eng_a.wr_addr = {4'd7, 4'd6, 4'd9};
      eng_a.wr_data = {wrd(7), wrd(6), wrd(9)};
      eng_a.wr_req = 3'b001;
      bad = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #2;
         if (!busy_a || !wr_en_a || wr_addr_a != AW'(k) || wr_data_a != '0 || eng_a.wr_gnt != '0)
            bad = 1'b1;
         chk($sformatf("clr_done_k%0d", k), 32'(done_a), 32'(k == 15));
         step();
      end
      chk("clr_sweep_ok", 32'(bad), 0);
      eng_a.rd_req = 3'b001;
      #2;
      chk("clr_after_busy", 32'(busy_a), 0);
      chk("clr_after_wr_gnt", 32'(eng_a.wr_gnt), 32'b001);
      chk("clr_after_rd_gnt", 32'(eng_a.rd_gnt), 32'b001);
      step();
      eng_a.wr_req = '0;
      eng_a.rd_req = 3'b001;
      eng_a.rd_addr = {4'd7, 4'd6, 4'd9};
      #2;
      chk("clr_rd2_gnt", 32'(eng_a.rd_gnt), 32'b001);
      step();
      eng_a.rd_req = '0;
      #2;
      chk("clr_rd5_val", 32'(eng_a.rd_data_val), 32'b001);
      chk("clr_rd5_data", eng_a.rd_data, 0);
      step();
      #2;
      chk("wr9_rd_val", 32'(eng_a.rd_data_val), 32'b001);
      chk("wr9_rd_data", eng_a.rd_data, wrd(9));
      step();

      // Restart at clear address 7: one done pulse, 16 cycles after the restart.
      done_cnt = 0;
      run_a = 1'b1;
      step();
      run_a = 1'b0;
      for (int k = 0; k < 7; k++) begin
         #2;
         done_cnt += int'(done_a);
         step();
      end
      run_a = 1'b1;
      #2;
      chk("rs_addr7", 32'(wr_addr_a), 7);
      done_cnt += int'(done_a);
      step();
      run_a = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #2;
         if (k == 0) chk("rs_addr0", 32'(wr_addr_a), 0);
         if (k == 15) chk("rs_done_last", 32'(done_a), 1);
         done_cnt += int'(done_a);
         step();
      end
      #2;
      chk("rs_busy_end", 32'(busy_a), 0);
      chk("rs_done_count", 32'(done_cnt), 1);

      // Reset at clear address 3: sweep abandoned, no done pulse.
      run_a = 1'b1;
      step();
      run_a = 1'b0;
      repeat (3) step();
      #2;
      chk("rstclr_addr3", 32'(wr_addr_a), 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #2;
      chk("rstclr_busy", 32'(busy_a), 0);
      chk("rstclr_wr_en", 32'(wr_en_a), 0);
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done_a || busy_a) bad = 1'b1;
         step();
         #2;
      end
      chk("rstclr_no_done", 32'(bad), 0);

      // Reset with two reads in flight discards their tags.
      step();
      eng_a.rd_addr = {4'd7, 4'd6, 4'd5};
      eng_a.rd_req = 3'b001;
      #2;
      chk("rstrd_gnt0", 32'(eng_a.rd_gnt), 32'b001);
      step();
      eng_a.rd_req = 3'b010;
      rst = 1'b1;
      step();
      rst = 1'b0;
      eng_a.rd_req = '0;
      #2;
      chk("rstrd_val1", 32'(eng_a.rd_data_val), 0);
      step();
      #2;
      chk("rstrd_val2", 32'(eng_a.rd_data_val), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_table_ram_arb.md
Name: data_table_ram_arb

Overview:
- Parametrised access arbiter and clear engine for the hash-table data RAM.
- Multiplexes CH_CNT engine read and write request channels onto one read port and one write port of the dual-port data RAM.
- Routes read data back to the requesting channel after the RAM read latency.
- Provides a working clear sweep that zero-fills the whole RAM, with the arbiter locked out while it runs.

Parameters:
- CH_CNT, 2, number of requesting channels (search, insert, delete, ...); must be ≥ 1.
- A_WIDTH, HEAD_PTR_WIDTH, RAM address width; the clear sweep covers 2**A_WIDTH words.
- D_WIDTH, $bits(ram_data_t), RAM word width.
- RAM_LATENCY, 2, cycles from ram_rd_en_o to valid ram_rd_data_i; must be ≥ 1.
- ARB_MODE, 1, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- rd_req_i  in  CH_CNT  per-channel read request.
- rd_addr_i  in  CH_CNT*A_WIDTH  per-channel read address; channel i occupies bits [i*A_WIDTH +: A_WIDTH].
- rd_gnt_o  out  CH_CNT  one-hot read grant, combinational, same cycle as the request.
- rd_data_o  out  D_WIDTH  read data, shared by all channels.
- rd_data_val_o  out  CH_CNT  one-hot; marks which channel owns rd_data_o.
- wr_req_i  in  CH_CNT  per-channel write request.
- wr_addr_i  in  CH_CNT*A_WIDTH  per-channel write address.
- wr_data_i  in  CH_CNT*D_WIDTH  per-channel write data.
- wr_gnt_o  out  CH_CNT  one-hot write grant, combinational.
- clear_ram_run_i  in  1  start (or restart) a clear sweep.
- clear_ram_done_o  out  1  one-cycle pulse when the sweep completes.
- busy_o  out  1  high while the sweep runs.
- ram_rd_addr_o  out  A_WIDTH  RAM read address.
- ram_rd_en_o  out  1  RAM read enable.
- ram_rd_data_i  in  D_WIDTH  RAM read data.
- ram_wr_addr_o  out  A_WIDTH  RAM write address.
- ram_wr_data_o  out  D_WIDTH  RAM write data.
- ram_wr_en_o  out  1  RAM write enable.

Behaviour:
- Reset values:
  - State is IDLE.
  - All grants, rd_data_val_o, clear_ram_done_o, busy_o, ram_rd_en_o and ram_wr_en_o are 0.
  - Round-robin pointers are 0.
  - The tag pipeline is cleared.
- Read and write arbitration are independent; each uses its own rr_arbiter instance.
- Grants are combinational from the requests, and the RAM port signals are driven the same cycle (no added request latency).
- At most one read grant and one write grant per cycle.
- A granted request is consumed. An ungranted channel must hold its request and address until granted.
- ARB_MODE=1 (round-robin):
  - Search starts at the index after the last granted channel.
  - The pointer updates only on a cycle with a grant.
  - Every continuously asserted request is granted within CH_CNT cycles.
- ARB_MODE=0 (fixed priority): highest index wins, as in the current mux; no fairness.
- Read return:
  - A shift register RAM_LATENCY deep carries the one-hot grant as a tag.
  - rd_data_val_o = tag at stage RAM_LATENCY; rd_data_o = ram_rd_data_i, unregistered.
  - Back-to-back reads are fully pipelined, giving one result per cycle.
- State machine:
  - IDLE -> CLEAR on clear_ram_run_i: clear address reset to 0, busy_o = 1.
  - CLEAR:
    - Writes zero to the clear address each cycle.
    - All rd_gnt_o/wr_gnt_o are forced to 0 and ram_rd_en_o = 0.
    - The address increments by 1 each cycle.
  - CLEAR -> IDLE after the write to address all-ones, with clear_ram_done_o pulsed the same cycle as that last write.
  - clear_ram_run_i during CLEAR restarts the sweep at address 0; no done pulse is issued for the aborted sweep.
- Reads granted before the sweep started still complete: the tag pipeline keeps shifting during CLEAR.
- Same-address read and write in one cycle: the RAM returns old data, and the arbiter does not bypass. Engines must not rely on forwarding.
- rst_i mid-sweep: returns to IDLE, no done pulse, and in-flight read tags are discarded.
- Address arithmetic is A_WIDTH-bit unsigned. The clear counter wraps at all-ones and terminates the sweep.
- The RAM instance is external to this block; the block drives the RAM port signals listed above.

Decomposition:
- Shared package hash_table: ram_data_t and HEAD_PTR_WIDTH (existing); add the ARB_FIXED/ARB_RR constants for ARB_MODE.
- One sub-module, rr_arbiter:
  - Parameters: N, MODE.
  - Inputs: req[N], advance.
  - Outputs: gnt[N], one-hot.
  - Contains the pointer register.
  - Instantiated twice, once for reads and once for writes.

Test Plan:
- CH_CNT=3, ARB_MODE=1, rd_req_i=3'b111 held for 6 cycles -> rd_gnt_o sequence 001,010,100,001,010,100; rd_data_val_o repeats the same sequence delayed by 2 cycles; data matches preloaded words at addresses 5, 6, 7.
- ARB_MODE=0, rd_req_i=3'b011 held -> rd_gnt_o stays 010 every cycle; channel 0 is never granted.
- Pulse clear_ram_run_i with A_WIDTH=4 -> busy_o high for 16 cycles; ram_wr_en_o with addresses 0..15 and data 0; clear_ram_done_o pulses once on the address-15 cycle; a subsequent read of address 9 returns 0.
- During clear, wr_req_i=3'b001 asserted -> wr_gnt_o=0 for the whole sweep; granted the first cycle after busy_o falls.
- Re-pulse clear_ram_run_i at clear address 7 -> sweep restarts at 0; exactly one done pulse, 16 cycles after the restart.
- rst_i asserted at clear address 3 with 2 reads in flight -> next cycle busy_o=0, rd_data_val_o=0; no clear_ram_done_o pulse.
